// File: rtl/scalar_writeback_unit_pkg.sv
// Shared codes and helpers for the scalar write-back stage and its FIFO.
package scalar_writeback_unit_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    // Register-file command codes driven on rf_signal.
    localparam logic [1:0] SCALAR_RF_NOP   = 2'b00;
    localparam logic [1:0] SCALAR_RF_WRITE = 2'b01;
    localparam logic [1:0] RF_NOP          = 2'b10;
    localparam logic [1:0] RF_FINISHED     = 2'b11;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_IDX_W-1:0] rd);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << rd;
    endfunction

endpackage

// File: rtl/scalar_writeback_unit_fifo.sv
// In-order circular buffer with two write ports (port 0 older) and one read port.
module writeback_fifo
    import scalar_writeback_unit_pkg::*;
#(
    parameter int LEN       = 32,
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n_i,
    input  logic                 wr0_en_i,
    input  logic [REG_IDX_W-1:0] wr0_rd_i,
    input  logic [LEN-1:0]       wr0_data_i,
    input  logic                 wr1_en_i,
    input  logic [REG_IDX_W-1:0] wr1_rd_i,
    input  logic [LEN-1:0]       wr1_data_i,
    input  logic                 rd_en_i,
    output logic [REG_IDX_W-1:0] head_rd_o,
    output logic [LEN-1:0]       head_data_o,
    output logic [PTR_WIDTH:0]   count_o,
    output logic [NUM_REGS-1:0]  queued_mask_o
);

    logic [REG_IDX_W-1:0] rd_q   [DEPTH];
    logic [LEN-1:0]       data_q [DEPTH];
    logic [DEPTH-1:0]     valid_q;
    logic [PTR_WIDTH-1:0] head_q, tail_q;
    logic [PTR_WIDTH:0]   count_q;

    logic [PTR_WIDTH-1:0] slot_a, slot_b;
    logic [PTR_WIDTH:0]   count_d;
    logic [PTR_WIDTH-1:0] tail_d, head_d;

    // Port 1 lands behind port 0 only when port 0 is also writing.
    assign slot_a  = tail_q;
    assign slot_b  = tail_q + PTR_WIDTH'(wr0_en_i);
    assign tail_d  = tail_q + PTR_WIDTH'(wr0_en_i) + PTR_WIDTH'(wr1_en_i);
    assign head_d  = head_q + PTR_WIDTH'(rd_en_i);
    assign count_d = count_q + (PTR_WIDTH+1)'(wr0_en_i) + (PTR_WIDTH+1)'(wr1_en_i)
                   - (PTR_WIDTH+1)'(rd_en_i);

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (rd_en_i)  valid_q[head_q] <= 1'b0;
            if (wr0_en_i) valid_q[slot_a] <= 1'b1;
            if (wr1_en_i) valid_q[slot_b] <= 1'b1;
        end
    end

    // NOTE: payload storage is not reset; valid_q alone decides what is live.
    always_ff @(posedge clk) begin
        if (wr0_en_i) begin
            rd_q[slot_a]   <= wr0_rd_i;
            data_q[slot_a] <= wr0_data_i;
        end
        if (wr1_en_i) begin
            rd_q[slot_b]   <= wr1_rd_i;
            data_q[slot_b] <= wr1_data_i;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        queued_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) queued_mask_o = queued_mask_o | rd_onehot(rd_q[i]);
        end
    end

    assign head_rd_o   = rd_q[head_q];
    assign head_data_o = data_q[head_q];
    assign count_o     = count_q;

endmodule

// File: rtl/scalar_writeback_unit.sv
// Write-back stage: merges ALU and load results, queues them, issues one RF write per cycle.
module scalar_writeback_unit
    import scalar_writeback_unit_pkg::*;
#(
    parameter int LEN       = 32,
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy_in,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [LEN-1:0]       alu_data,
    output logic                 alu_ready,
    input  logic                 lsu_valid,
    input  logic [REG_IDX_W-1:0] lsu_rd,
    input  logic [LEN-1:0]       lsu_data,
    output logic                 lsu_ready,
    output logic [1:0]           rf_signal,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [LEN-1:0]       wb_data,
    output logic                 write_back_enabled,
    output logic [NUM_REGS-1:0]  pending_mask,
    output logic [PTR_WIDTH:0]   fifo_count
);

    localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);

    logic [PTR_WIDTH:0]   count;
    logic [PTR_WIDTH:0]   free;
    logic                 lsu_store, alu_store, deq;
    logic [REG_IDX_W-1:0] head_rd;
    logic [LEN-1:0]       head_data;
    logic [NUM_REGS-1:0]  queued_mask;

    logic                 wbe_q, wbe_d;
    logic [1:0]           rf_signal_q, rf_signal_d;
    logic [REG_IDX_W-1:0] wb_rd_q, wb_rd_d;
    logic [LEN-1:0]       wb_data_q, wb_data_d;

    // Credit only the registered occupancy; a same-cycle pop does not free a slot.
    assign free      = DEPTH_C - count;
    assign lsu_ready = rst && (free >= 1);
    assign alu_ready = rst && (lsu_valid ? (free >= 2) : (free >= 1));

    // x0 writes are handshaken but dropped before the FIFO.
    assign lsu_store = lsu_valid && lsu_ready && (lsu_rd != '0);
    assign alu_store = alu_valid && alu_ready && (alu_rd != '0);
    assign deq       = rdy_in && (count != '0);

    writeback_fifo #(
        .LEN       (LEN),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n_i       (rst),
        .wr0_en_i      (lsu_store),
        .wr0_rd_i      (lsu_rd),
        .wr0_data_i    (lsu_data),
        .wr1_en_i      (alu_store),
        .wr1_rd_i      (alu_rd),
        .wr1_data_i    (alu_data),
        .rd_en_i       (deq),
        .head_rd_o     (head_rd),
        .head_data_o   (head_data),
        .count_o       (count),
        .queued_mask_o (queued_mask)
    );

    always_comb begin
        wbe_d       = wbe_q;
        rf_signal_d = rf_signal_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        if (rdy_in) begin
            if (deq) begin
                wbe_d       = 1'b1;
                rf_signal_d = SCALAR_RF_WRITE;
                wb_rd_d     = head_rd;
                wb_data_d   = head_data;
            end else begin
                wbe_d       = 1'b0;
                rf_signal_d = SCALAR_RF_NOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wbe_q       <= 1'b0;
            rf_signal_q <= SCALAR_RF_NOP;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            wbe_q       <= wbe_d;
            rf_signal_q <= rf_signal_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign write_back_enabled = wbe_q;
    assign rf_signal          = rf_signal_q;
    assign wb_rd              = wb_rd_q;
    assign wb_data            = wb_data_q;
    assign fifo_count         = count;
    assign pending_mask       = (queued_mask | (wbe_q ? rd_onehot(wb_rd_q) : '0))
                              & ~{{(NUM_REGS-1){1'b0}}, 1'b1};

endmodule

// File: tb/tb_scalar_writeback_unit.sv
// Directed bench for scalar_writeback_unit with hand-computed expectations.
module tb_scalar_writeback_unit;
    import scalar_writeback_unit_pkg::*;

    localparam int LEN = 32;

    logic            clk = 1'b0;
    logic            rst, rdy_in;
    logic            alu_valid, lsu_valid;
    logic [4:0]      alu_rd, lsu_rd;
    logic [LEN-1:0]  alu_data, lsu_data;
    logic            alu_ready, lsu_ready;
    logic [1:0]      rf_signal;
    logic [4:0]      wb_rd;
    logic [LEN-1:0]  wb_data;
    logic            write_back_enabled;
    logic [31:0]     pending_mask;
    logic [2:0]      fifo_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    scalar_writeback_unit #(.LEN(LEN), .DEPTH(4), .PTR_WIDTH(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .rdy_in             (rdy_in),
        .alu_valid          (alu_valid),
        .alu_rd             (alu_rd),
        .alu_data           (alu_data),
        .alu_ready          (alu_ready),
        .lsu_valid          (lsu_valid),
        .lsu_rd             (lsu_rd),
        .lsu_data           (lsu_data),
        .lsu_ready          (lsu_ready),
        .rf_signal          (rf_signal),
        .wb_rd              (wb_rd),
        .wb_data            (wb_data),
        .write_back_enabled (write_back_enabled),
        .pending_mask       (pending_mask),
        .fifo_count         (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v; alu_rd = rd; alu_data = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = v; lsu_rd = rd; lsu_data = d;
    endtask

    task automatic check_issue(input string tag, input logic [4:0] rd, input logic [31:0] d);
        check({tag, "_wbe"}, write_back_enabled, 1'b1);
        check({tag, "_rf"},  rf_signal, SCALAR_RF_WRITE);
        check({tag, "_rd"},  wb_rd, rd);
        check({tag, "_data"}, wb_data, d);
    endtask

    initial begin
        rst = 1'b0; rdy_in = 1'b1;
        drive_alu(1'b1, 5'd7, 32'hDEAD);
        drive_lsu(1'b0, 5'd0, 32'h0);

        // Reset held two cycles with a live ALU request.
        tick(); tick();
        check("rst_wbe", write_back_enabled, 1'b0);
        check("rst_rf", rf_signal, SCALAR_RF_NOP);
        check("rst_rd", wb_rd, 5'd0);
        check("rst_data", wb_data, 32'h0);
        check("rst_pend", pending_mask, 32'h0);
        check("rst_alu_ready", alu_ready, 1'b0);
        check("rst_lsu_ready", lsu_ready, 1'b0);
        drive_alu(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        tick();
        check("rst_count", fifo_count, 3'd0);

        // Single ALU result: one-cycle queue latency, then issue.
        drive_alu(1'b1, 5'd5, 32'h1234);
        #1;
        check("alu_ready_empty", alu_ready, 1'b1);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        check("single_count", fifo_count, 3'd1);
        check("single_wbe_early", write_back_enabled, 1'b0);
        check("single_pend_q", pending_mask, 32'h20);
        tick();
        check_issue("single", 5'd5, 32'h1234);
        check("single_pend_issue", pending_mask, 32'h20);
        check("single_count_drained", fifo_count, 3'd0);
        tick();
        check("single_wbe_off", write_back_enabled, 1'b0);
        check("single_rf_nop", rf_signal, SCALAR_RF_NOP);
        check("single_pend_clear", pending_mask, 32'h0);
        check("single_rd_hold", wb_rd, 5'd5);

        // Both sources in one cycle to the same rd: LSU retires first.
        drive_lsu(1'b1, 5'd3, 32'hA);
        drive_alu(1'b1, 5'd3, 32'hB);
        #1;
        check("dual_lsu_ready", lsu_ready, 1'b1);
        check("dual_alu_ready", alu_ready, 1'b1);
        tick();
        drive_lsu(1'b0, 5'd0, 32'h0);
        drive_alu(1'b0, 5'd0, 32'h0);
        check("dual_count", fifo_count, 3'd2);
        tick();
        check_issue("dual_first", 5'd3, 32'hA);
        tick();
        check_issue("dual_second", 5'd3, 32'hB);
        tick();
        check("dual_done", write_back_enabled, 1'b0);

        // Fill while stalled.
        rdy_in = 1'b0;
        drive_lsu(1'b1, 5'd1, 32'h11);
        drive_alu(1'b1, 5'd2, 32'h22);
        tick();
        drive_lsu(1'b1, 5'd4, 32'h44);
        drive_alu(1'b1, 5'd6, 32'h66);
        check("fill_count2", fifo_count, 3'd2);
        tick();
        check("full_count", fifo_count, 3'd4);
        check("full_lsu_ready", lsu_ready, 1'b0);
        check("full_alu_ready", alu_ready, 1'b0);
        check("full_pend", pending_mask, 32'h56);
        check("full_wbe_hold", write_back_enabled, 1'b0);
        drive_lsu(1'b0, 5'd0, 32'h0);
        drive_alu(1'b0, 5'd0, 32'h0);
        rdy_in = 1'b1;
        tick();
        check_issue("pop1", 5'd1, 32'h11);
        check("pop1_count", fifo_count, 3'd3);

        // One free slot with both valid: only the load fits.
        rdy_in = 1'b0;
        drive_lsu(1'b1, 5'd8, 32'h88);
        drive_alu(1'b1, 5'd9, 32'h99);
        #1;
        check("free1_lsu_ready", lsu_ready, 1'b1);
        check("free1_alu_ready", alu_ready, 1'b0);
        tick();
        drive_lsu(1'b0, 5'd0, 32'h0);
        drive_alu(1'b0, 5'd0, 32'h0);
        check("free1_count", fifo_count, 3'd4);
        check_issue("stall_hold", 5'd1, 32'h11);
        check("free1_pend", pending_mask, 32'h156);
        rdy_in = 1'b1;
        tick(); check_issue("drain2", 5'd2, 32'h22);
        tick(); check_issue("drain4", 5'd4, 32'h44);
        tick(); check_issue("drain6", 5'd6, 32'h66);
        tick(); check_issue("drain8", 5'd8, 32'h88);
        tick();
        check("drain_wbe_off", write_back_enabled, 1'b0);
        check("drain_count", fifo_count, 3'd0);

        // x0 writes are accepted but never stored or issued.
        drive_alu(1'b1, 5'd0, 32'hFFFF);
        #1;
        check("x0_alu_ready", alu_ready, 1'b1);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        check("x0_count", fifo_count, 3'd0);
        check("x0_pend", pending_mask, 32'h0);
        tick();
        check("x0_no_wbe", write_back_enabled, 1'b0);

        // Reset with three entries queued.
        rdy_in = 1'b0;
        drive_lsu(1'b1, 5'd10, 32'hA0);
        drive_alu(1'b1, 5'd11, 32'hB0);
        tick();
        drive_lsu(1'b0, 5'd0, 32'h0);
        drive_alu(1'b1, 5'd12, 32'hC0);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        check("mid_count3", fifo_count, 3'd3);
        check("mid_pend3", pending_mask, 32'h1C00);
        rst = 1'b0;
        tick();
        check("mid_rst_count", fifo_count, 3'd0);
        check("mid_rst_pend", pending_mask, 32'h0);
        check("mid_rst_wbe", write_back_enabled, 1'b0);
        check("mid_rst_rd", wb_rd, 5'd0);
        rst = 1'b1;
        rdy_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_post_wbe", write_back_enabled, 1'b0);
        end
        check("mid_post_count", fifo_count, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
